// File: rtl/raster_pkg.sv
// Shared types and constants for the raster traversal stage and its edge evaluator.
package raster_pkg;

  localparam int COORD_W      = 16;
  localparam int EDGE_W       = 32;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  typedef enum logic [2:0] {IDLE, AREA, INIT, WALK, DONE} state_t;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [EDGE_W-1:0]  edge_t;

  function automatic edge_t sext(input coord_t v);
    return {{(EDGE_W-COORD_W){v[COORD_W-1]}}, v};
  endfunction

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/edge_function.sv
// Combinational edge evaluator: edge i runs from vertex i to vertex (i+1)%3,
// e_i(p) = (px - xi)*a_i - (py - yi)*b_i with a_i = dy, b_i = dx of that edge.
module edge_function
  import raster_pkg::*;
(
  input  coord_t i_vx [3],
  input  coord_t i_vy [3],
  input  coord_t i_px,
  input  coord_t i_py,
  output edge_t  o_e  [3],
  output coord_t o_a  [3],
  output coord_t o_b  [3]
);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      localparam int NB = (gi + 1) % 3;
      edge_t w_dx;
      edge_t w_dy;

      // Vertex differences stay within 16 bits for the legal coordinate range.
      assign o_a[gi] = i_vy[NB] - i_vy[gi];
      assign o_b[gi] = i_vx[NB] - i_vx[gi];
      assign w_dx    = sext(i_px) - sext(i_vx[gi]);
      assign w_dy    = sext(i_py) - sext(i_vy[gi]);
      assign o_e[gi] = w_dx * sext(o_a[gi]) - w_dy * sext(o_b[gi]);
    end
  endgenerate

endmodule

// File: rtl/raster_traverse.sv
// Bounding-box raster walker: accepts a triangle, clips its bbox to the screen,
// steps the three edge values incrementally and emits one fragment per covered pixel.
module raster_traverse
  import raster_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [15:0] v0x,
  input  logic [15:0] v0y,
  input  logic [15:0] v1x,
  input  logic [15:0] v1y,
  input  logic [15:0] v2x,
  input  logic [15:0] v2y,
  output logic        frag_valid,
  input  logic        frag_ready,
  output logic [15:0] frag_x,
  output logic [15:0] frag_y,
  output logic [31:0] frag_w0,
  output logic [31:0] frag_w1,
  output logic [31:0] frag_w2,
  output logic        busy,
  output logic        tri_done
);

  localparam coord_t X_LAST = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LAST = coord_t'(SCREEN_H - 1);

  state_t r_state;
  coord_t r_vx [3];
  coord_t r_vy [3];
  coord_t r_xmin, r_xmax, r_ymin, r_ymax;
  coord_t r_x, r_y;
  logic   r_neg;
  edge_t  r_e   [3];
  edge_t  r_row [3];
  coord_t r_a   [3];
  coord_t r_b   [3];

  logic   r_frag_valid;
  coord_t r_frag_x, r_frag_y;
  edge_t  r_frag_w [3];

  coord_t w_in_x [3];
  coord_t w_in_y [3];
  coord_t w_minx, w_maxx, w_miny, w_maxy;
  coord_t w_bx_lo, w_bx_hi, w_by_lo, w_by_hi;
  coord_t w_px, w_py;
  edge_t  w_e [3];
  coord_t w_a [3];
  coord_t w_b [3];
  edge_t  w_e_step   [3];
  edge_t  w_row_step [3];
  edge_t  w_wt       [3];
  logic   [2:0] w_ge, w_le;
  logic   w_inside, w_slot_free, w_load;

  assign w_in_x[0] = coord_t'(v0x);
  assign w_in_x[1] = coord_t'(v1x);
  assign w_in_x[2] = coord_t'(v2x);
  assign w_in_y[0] = coord_t'(v0y);
  assign w_in_y[1] = coord_t'(v1y);
  assign w_in_y[2] = coord_t'(v2y);

  assign w_minx  = min3(w_in_x[0], w_in_x[1], w_in_x[2]);
  assign w_maxx  = max3(w_in_x[0], w_in_x[1], w_in_x[2]);
  assign w_miny  = min3(w_in_y[0], w_in_y[1], w_in_y[2]);
  assign w_maxy  = max3(w_in_y[0], w_in_y[1], w_in_y[2]);
  assign w_bx_lo = (w_minx < coord_t'(0)) ? coord_t'(0) : w_minx;
  assign w_bx_hi = (w_maxx > X_LAST) ? X_LAST : w_maxx;
  assign w_by_lo = (w_miny < coord_t'(0)) ? coord_t'(0) : w_miny;
  assign w_by_hi = (w_maxy > Y_LAST) ? Y_LAST : w_maxy;

  // The shared evaluator sees v2 in AREA (signed area) and the bbox corner in INIT.
  assign w_px = (r_state == INIT) ? r_xmin : r_vx[2];
  assign w_py = (r_state == INIT) ? r_ymin : r_vy[2];

  edge_function u_edge (
    .i_vx (r_vx),
    .i_vy (r_vy),
    .i_px (w_px),
    .i_py (w_py),
    .o_e  (w_e),
    .o_a  (w_a),
    .o_b  (w_b)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_step
      assign w_e_step[gi]   = r_e[gi] + sext(r_a[gi]);
      assign w_row_step[gi] = r_row[gi] - sext(r_b[gi]);
      assign w_ge[gi]       = (r_e[gi] >= edge_t'(0));
      assign w_le[gi]       = (r_e[gi] <= edge_t'(0));
      assign w_wt[gi]       = r_neg ? -r_e[gi] : r_e[gi];
    end
  endgenerate

  assign w_inside    = r_neg ? (&w_le) : (&w_ge);
  assign w_slot_free = !r_frag_valid || frag_ready;
  assign w_load      = (r_state == WALK) && w_slot_free && w_inside;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_frag_valid <= 1'b0;
      r_frag_x     <= '0;
      r_frag_y     <= '0;
      r_neg        <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      for (int i = 0; i < 3; i++) begin
        r_frag_w[i] <= '0;
      end
    end else begin
      if (w_load) begin
        r_frag_valid <= 1'b1;
        r_frag_x     <= r_x;
        r_frag_y     <= r_y;
        for (int i = 0; i < 3; i++) begin
          r_frag_w[i] <= w_wt[i];
        end
      end else if (frag_ready) begin
        r_frag_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (tri_valid) begin
            for (int i = 0; i < 3; i++) begin
              r_vx[i] <= w_in_x[i];
              r_vy[i] <= w_in_y[i];
            end
            r_xmin  <= w_bx_lo;
            r_xmax  <= w_bx_hi;
            r_ymin  <= w_by_lo;
            r_ymax  <= w_by_hi;
            r_state <= AREA;
          end
        end
        AREA: begin
          if (w_e[0] == edge_t'(0) || r_xmin > r_xmax || r_ymin > r_ymax) begin
            r_state <= DONE;
          end else begin
            r_neg   <= w_e[0][EDGE_W-1];
            r_state <= INIT;
          end
        end
        INIT: begin
          for (int i = 0; i < 3; i++) begin
            r_e[i]   <= w_e[i];
            r_row[i] <= w_e[i];
            r_a[i]   <= w_a[i];
            r_b[i]   <= w_b[i];
          end
          r_x     <= r_xmin;
          r_y     <= r_ymin;
          r_state <= WALK;
        end
        WALK: begin
          // The walker only moves when the current pixel's fragment has somewhere to go.
          if (w_slot_free) begin
            if (r_x < r_xmax) begin
              r_x <= r_x + coord_t'(1);
              for (int i = 0; i < 3; i++) begin
                r_e[i] <= w_e_step[i];
              end
            end else if (r_y < r_ymax) begin
              r_y <= r_y + coord_t'(1);
              r_x <= r_xmin;
              for (int i = 0; i < 3; i++) begin
                r_row[i] <= w_row_step[i];
                r_e[i]   <= w_row_step[i];
              end
            end else begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (w_slot_free) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tri_ready  = (r_state == IDLE) && !rst;
  assign busy       = (r_state != IDLE);
  assign tri_done   = (r_state == DONE) && w_slot_free && !rst;
  assign frag_valid = r_frag_valid;
  assign frag_x     = r_frag_x;
  assign frag_y     = r_frag_y;
  assign frag_w0    = r_frag_w[0];
  assign frag_w1    = r_frag_w[1];
  assign frag_w2    = r_frag_w[2];

endmodule

// File: tb/tb_raster_traverse.sv
// Scoreboard bench for raster_traverse: a direct per-pixel edge model fills the
// expected-fragment queue, and a negedge monitor pops and compares each accepted fragment.
module tb_raster_traverse;

  logic        clk = 1'b0;
  logic        rst;
  logic        tri_valid;
  logic        tri_ready;
  logic [15:0] v0x, v0y, v1x, v1y, v2x, v2y;
  logic        frag_valid;
  logic        frag_ready;
  logic [15:0] frag_x, frag_y;
  logic [31:0] frag_w0, frag_w1, frag_w2;
  logic        busy;
  logic        tri_done;

  always #5 clk = ~clk;

  raster_traverse dut (
    .clk        (clk),
    .rst        (rst),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .v0x        (v0x),
    .v0y        (v0y),
    .v1x        (v1x),
    .v1y        (v1y),
    .v2x        (v2x),
    .v2y        (v2y),
    .frag_valid (frag_valid),
    .frag_ready (frag_ready),
    .frag_x     (frag_x),
    .frag_y     (frag_y),
    .frag_w0    (frag_w0),
    .frag_w1    (frag_w1),
    .frag_w2    (frag_w2),
    .busy       (busy),
    .tri_done   (tri_done)
  );

  typedef struct {
    int x;
    int y;
    int w0;
    int w1;
    int w2;
  } frag_t;

  frag_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    acc_cyc = 0, first_cyc = -1, ready_cyc = -1, done_cyc = -1;
  int    frag_cnt = 0, done_cnt = 0;
  bit    armed = 1'b0;
  bit    hold_prev = 1'b0;
  logic [15:0] prev_x, prev_y;
  logic [31:0] prev_w0, prev_w1, prev_w2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int edge_val(input int ax, input int ay, input int bx, input int by,
                                  input int x, input int y);
    return (x - ax) * (by - ay) - (y - ay) * (bx - ax);
  endfunction

  // Reference: evaluate every bbox pixel directly, no incremental stepping.
  task automatic push_expected(input int x0, input int y0, input int x1, input int y1,
                               input int x2, input int y2);
    int area, xmin, xmax, ymin, ymax, e1, e2, e3;
    bit neg, ins;
    area = edge_val(x0, y0, x1, y1, x2, y2);
    if (area == 0) return;
    neg  = (area < 0);
    xmin = (x0 < x1) ? x0 : x1;  xmin = (xmin < x2) ? xmin : x2;  if (xmin < 0) xmin = 0;
    ymin = (y0 < y1) ? y0 : y1;  ymin = (ymin < y2) ? ymin : y2;  if (ymin < 0) ymin = 0;
    xmax = (x0 > x1) ? x0 : x1;  xmax = (xmax > x2) ? xmax : x2;  if (xmax > 639) xmax = 639;
    ymax = (y0 > y1) ? y0 : y1;  ymax = (ymax > y2) ? ymax : y2;  if (ymax > 479) ymax = 479;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x++) begin
        e1  = edge_val(x0, y0, x1, y1, x, y);
        e2  = edge_val(x1, y1, x2, y2, x, y);
        e3  = edge_val(x2, y2, x0, y0, x, y);
        ins = neg ? (e1 <= 0 && e2 <= 0 && e3 <= 0) : (e1 >= 0 && e2 >= 0 && e3 >= 0);
        if (ins) exp_q.push_back('{x, y, neg ? -e1 : e1, neg ? -e2 : e2, neg ? -e3 : e3});
      end
    end
  endtask

  always @(negedge clk) begin
    frag_t f;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check_val("hold_valid", frag_valid, 1);
        check_val("hold_x", frag_x, prev_x);
        check_val("hold_y", frag_y, prev_y);
        check_val("hold_w0", frag_w0, prev_w0);
        check_val("hold_w1", frag_w1, prev_w1);
        check_val("hold_w2", frag_w2, prev_w2);
      end
      if (tri_valid && tri_ready) begin
        acc_cyc = cyc; first_cyc = -1; ready_cyc = -1; armed = 1'b1;
      end else if (armed && tri_ready && ready_cyc < 0) begin
        ready_cyc = cyc;
      end
      if (armed && frag_valid && first_cyc < 0) first_cyc = cyc;
      if (frag_valid && frag_ready) begin
        frag_cnt++;
        if (exp_q.size() == 0) begin
          check_val("frag_extra", exp_q.size(), 1);
        end else begin
          f = exp_q.pop_front();
          $display("frag (%0d,%0d) w=(%0d,%0d,%0d)", frag_x, frag_y, frag_w0, frag_w1, frag_w2);
          check_val("frag_x", frag_x, f.x);
          check_val("frag_y", frag_y, f.y);
          check_val("frag_w0", $signed(frag_w0), f.w0);
          check_val("frag_w1", $signed(frag_w1), f.w1);
          check_val("frag_w2", $signed(frag_w2), f.w2);
        end
      end
      if (tri_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hold_prev = frag_valid && !frag_ready;
      prev_x = frag_x;  prev_y = frag_y;
      prev_w0 = frag_w0;  prev_w1 = frag_w1;  prev_w2 = frag_w2;
    end
  end

  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2);
    bit ok;
    push_expected(x0, y0, x1, y1, x2, y2);
    @(posedge clk); #1;
    v0x = 16'(x0); v0y = 16'(y0); v1x = 16'(x1); v1y = 16'(y1); v2x = 16'(x2); v2y = 16'(y2);
    tri_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = tri_ready;
    end
    check_val("accept_seen", ok, 1);
    @(posedge clk); #1;
    tri_valid = 1'b0;
  endtask

  task automatic wait_frags(input int f0, input int n);
    int i;
    for (i = 0; i < 500 && (frag_cnt - f0) < n; i++) @(negedge clk);
    check_val("frag_wait_timeout", (frag_cnt - f0) >= n, 1);
  endtask

  task automatic run_tri(input string name, input int x0, input int y0, input int x1,
                         input int y1, input int x2, input int y2, input int exp_n,
                         input bit bp);
    int f0, d0;
    f0 = frag_cnt;
    d0 = done_cnt;
    send_tri(x0, y0, x1, y1, x2, y2);
    if (bp) begin
      wait_frags(f0, 4);
      @(posedge clk); #1 frag_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1 frag_ready = 1'b1;
    end
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_val("done_count", done_cnt - d0, 1);
    check_val("frag_count", frag_cnt - f0, exp_n);
    check_val("queue_empty", exp_q.size(), 0);
    $display("tri %s: %0d fragments, done at +%0d", name, frag_cnt - f0, done_cyc - acc_cyc);
  endtask

  initial begin
    int f0, d0;
    rst = 1'b1; tri_valid = 1'b0; frag_ready = 1'b1;
    v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_frag_valid", frag_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_tri_ready", tri_ready, 0);
    check_val("rst_tri_done", tri_done, 0);
    check_val("rst_frag_x", frag_x, 0);
    check_val("rst_frag_w0", frag_w0, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("idle_tri_ready", tri_ready, 1);

    run_tri("basic", 0, 0, 4, 0, 0, 4, 15, 1'b0);
    check_val("basic_first_lat", first_cyc - acc_cyc, 4);

    run_tri("reverse", 0, 0, 0, 4, 4, 0, 15, 1'b0);
    check_val("reverse_first_lat", first_cyc - acc_cyc, 4);

    run_tri("degenerate", 0, 0, 2, 2, 4, 4, 0, 1'b0);
    check_val("degen_done_lat", done_cyc - acc_cyc, 2);
    check_val("degen_ready_lat", ready_cyc - acc_cyc, 3);

    run_tri("backpressure", 0, 0, 4, 0, 0, 4, 15, 1'b1);

    run_tri("clip", -2, -2, 6, -2, -2, 6, 15, 1'b0);

    // Reset while walking: pending work is dropped and no completion is signalled.
    f0 = frag_cnt;
    d0 = done_cnt;
    send_tri(0, 0, 4, 0, 0, 4);
    wait_frags(f0, 5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("rstwalk_frag_valid", frag_valid, 0);
    check_val("rstwalk_busy", busy, 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    check_val("rstwalk_no_done", done_cnt - d0, 0);

    run_tri("after_reset", -2, -2, 6, -2, -2, 6, 15, 1'b0);
    check_val("after_reset_first_lat", first_cyc - acc_cyc, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
